stm_audio_rx_fifo: RTL
======================

Name: stm_audio_rx_fifo

Overview:
- Upstream stage between the STM32 parallel audio bus (GPIO_0[15:0], STM_AUDIO_WR, STM_AUDIO_READY) and Audio_Controller's write port.
- Synchronizes the asynchronous STM write strobe and captures 16-bit samples into a small FIFO.
- Primes the FIFO, then drains one sample per codec slot: `write_audio_out` pulses whenever `audio_out_allowed` is high.
- Decouples STM32 timing jitter from codec demand and exposes overflow/underrun statistics for HEX debug.

Parameters:
- DATA_WIDTH, 16, sample width (both channels carry the same sample)
- ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH entries (16)
- PRIME_LEVEL, 8, FIFO level required before draining starts or resumes
- SYNC_STAGES, 2, synchronizer flops on stm_wr and stm_data (≥2)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- stm_data  in  DATA_WIDTH  STM32 sample bus, asynchronous
- stm_wr  in  1  STM32 write strobe, asynchronous, level
- stm_ready  out  1  to STM32: space available
- mute  in  1  force written samples to zero
- audio_out_allowed  in  1  from Audio_Controller
- left_channel_audio_out  out  DATA_WIDTH  sample to Audio_Controller
- right_channel_audio_out  out  DATA_WIDTH  identical to left
- write_audio_out  out  1  one-cycle write strobe to Audio_Controller
- fifo_level  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH
- overflow_count  out  8  saturating count of dropped samples
- underrun_count  out  8  saturating count of underrun events

Behaviour:
- Decided: one clock `clk`; `reset` is synchronous, active-high.
- Reset values:
  - stm_ready=0, write_audio_out=0, left/right=0, fifo_level=0, both counters=0.
  - Pointers=0, FSM=PRIME.
  - Synchronizer flops=0, so a strobe already high at reset release is seen as a rising edge once.
- Capture path:
  - stm_wr and stm_data pass through SYNC_STAGES flops in parallel, so they stay aligned.
  - Rising edge detected on the last wr stage vs one further delayed copy.
  - On that edge, push the aligned data stage.
  - STM contract: data stable from ≥3 clk before the WR rise until the WR fall.
  - One push per rising edge, however long WR stays high.
- Push when full (fifo_level==2**ADDR_WIDTH):
  - Sample dropped; overflow_count increments, saturating at 255.
  - Full is evaluated on the pre-pop level. A push in the same cycle as a pop while full is still dropped.
- stm_ready: registered, =1 when fifo_level < 2**ADDR_WIDTH-2 (headroom for strobes already in the synchronizer); 0 in reset.
- FIFO:
  - Circular buffer with ADDR_WIDTH-bit pointers that wrap modulo depth.
  - fifo_level = push-only +1, pop-only −1, push+pop unchanged.
- Drain FSM states: PRIME, IDLE, LOAD, STROBE, HOLD.
  - PRIME: no pops, no strobes. Go to IDLE when fifo_level ≥ PRIME_LEVEL.
  - IDLE:
    - If audio_out_allowed and not empty → LOAD.
    - If audio_out_allowed and empty → underrun: underrun_count +1 (saturating), go to PRIME.
    - Otherwise stay.
  - LOAD: pop the head. left/right <= mute ? 0 : head (registered) → STROBE.
  - STROBE: write_audio_out=1 for exactly this cycle; left/right held → HOLD.
  - HOLD: one cycle with audio_out_allowed ignored (lets the controller update allowed) → IDLE.
  - Minimum spacing between write strobes: 4 cycles.
  - left/right hold their last value between strobes and are stable while write_audio_out=1.
- Underrun never writes filler samples; silence comes from the codec. One underrun event is counted per drop to PRIME.
- mute: sampled in LOAD. It does not stop pops or the level bookkeeping.
- Reset asserted mid-operation: FIFO contents discarded, all state returns to reset values on the next clk edge, any in-progress strobe aborted.
- fifo_level is never negative and never exceeds depth; pop never occurs when empty.

Test Plan:
- Reset, then 8 STM writes 0x0001..0x0008 (WR high 5 clk, low 5 clk), audio_out_allowed=1 → no strobe until level=8. Then 8 strobes ≥4 clk apart with left=right=0x0001..0x0008 in order. Then exactly one underrun (count=1), FSM in PRIME, no further strobes.
- 20 writes 0x1000..0x1013 with audio_out_allowed=0 → level=16, overflow_count=4, stm_ready falls once level reaches 14. Enabling drain yields 0x1000..0x100F only.
- WR held high 100 clk with data 0xBEEF → exactly one push (level +1).
- mute=1 during drain of 0x7FFF,0x8000 → two strobes carrying 0x0000, level decreases by 2.
- Push edge coincides with LOAD pop at level 16 → level stays 16 minus 1 = 15, pushed sample dropped, overflow_count +1.
- Reset pulsed at level 10 while in STROBE → next cycle write_audio_out=0, level=0, outputs 0, counters 0, stm_ready=0 then 1 after one cycle.

Source files
------------

// File: rtl/stm_audio_rx_fifo_if.sv
// STM32 audio bus plus Audio_Controller write port, as seen by stm_audio_rx_fifo.
// The slave side is the FIFO block. The master side is the STM32, the codec controller and the debug display.
interface stm_audio_rx_fifo_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] stm_data;
  logic                  stm_wr;
  logic                  stm_ready;
  logic                  mute;
  logic                  audio_out_allowed;
  logic [DATA_WIDTH-1:0] left_channel_audio_out;
  logic [DATA_WIDTH-1:0] right_channel_audio_out;
  logic                  write_audio_out;
  logic [ADDR_WIDTH:0]   fifo_level;
  logic [7:0]            overflow_count;
  logic [7:0]            underrun_count;

  modport master (
    output stm_data, stm_wr, mute, audio_out_allowed,
    input  stm_ready, left_channel_audio_out, right_channel_audio_out,
           write_audio_out, fifo_level, overflow_count, underrun_count
  );

  modport slave (
    input  stm_data, stm_wr, mute, audio_out_allowed,
    output stm_ready, left_channel_audio_out, right_channel_audio_out,
           write_audio_out, fifo_level, overflow_count, underrun_count
  );
endinterface

// File: rtl/stm_audio_rx_fifo.sv
// Captures asynchronous STM32 audio samples into a small FIFO.
// After priming, it drains one sample per codec slot into Audio_Controller.
module stm_audio_rx_fifo #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned PRIME_LEVEL = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  stm_audio_rx_fifo_if.slave    bus
);
  localparam int unsigned       DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] READY_L = (ADDR_WIDTH+1)'(DEPTH - 2);
  localparam logic [ADDR_WIDTH:0] PRIME_L = (ADDR_WIDTH+1)'(PRIME_LEVEL);

  typedef enum logic [2:0] {PRIME, IDLE, LOAD, STROBE, HOLD} state_e;

  // Strobe and data are synchronized in parallel so the pushed word lines up with the detected edge.
  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic                   wr_dly_q;
  logic [DATA_WIDTH-1:0]  data_sync_q [SYNC_STAGES];

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]    level_q, level_d;
  logic [7:0]             ovf_q, ovf_d;
  logic                   ready_q, ready_d;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  sample_q;
  logic                   write_q;
  logic [7:0]             udr_q;

  logic push_req, full, empty, do_push, pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sync_q <= '0;
      wr_dly_q  <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], bus.stm_wr};
      wr_dly_q       <= wr_sync_q[SYNC_STAGES-1];
      data_sync_q[0] <= bus.stm_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  // Full is judged on the pre-pop level, so a push that collides with a pop while full is still dropped.
  always_comb begin
    push_req = wr_sync_q[SYNC_STAGES-1] & ~wr_dly_q;
    full     = (level_q == DEPTH_L);
    empty    = (level_q == '0);
    do_push  = push_req & ~full;
    pop      = (state_q == LOAD);
    wr_ptr_d = do_push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (push_req && full && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    ready_d = (level_q < READY_L);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_sync_q[SYNC_STAGES-1];
  end

  // HOLD gives the controller a cycle to update audio_out_allowed, so strobes are at least 4 cycles apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PRIME;
      sample_q <= '0;
      write_q  <= 1'b0;
      udr_q    <= '0;
    end else begin
      write_q <= 1'b0;
      case (state_q)
        PRIME: if (level_q >= PRIME_L) state_q <= IDLE;
        IDLE: begin
          if (bus.audio_out_allowed) begin
            if (empty) begin
              if (udr_q != 8'hFF) udr_q <= udr_q + 8'd1;
              state_q <= PRIME;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          sample_q <= bus.mute ? '0 : mem_q[rd_ptr_q];
          write_q  <= 1'b1;
          state_q  <= STROBE;
        end
        STROBE:  state_q <= HOLD;
        HOLD:    state_q <= IDLE;
        default: state_q <= PRIME;
      endcase
    end
  end

  assign bus.stm_ready               = ready_q;
  assign bus.left_channel_audio_out  = sample_q;
  assign bus.right_channel_audio_out = sample_q;
  assign bus.write_audio_out         = write_q;
  assign bus.fifo_level              = level_q;
  assign bus.overflow_count          = ovf_q;
  assign bus.underrun_count          = udr_q;
endmodule
